order_tx: RTL and testbench

ORDER_TX -- requirements
Module: order_tx

---
 rtl/order_pkg.sv | 49 ++++
 rtl/order_tx_hold.sv | 45 ++++
 rtl/order_tx.sv | 158 +++++++++++++++
 tb/tb_order_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_pkg.sv
// Shared order/packet definitions for the order transmitter and the market-data receiver.
// ORDER_TX_CHECKSUM_EN selects the trailing XOR checksum byte in order_tx.
package order_pkg;

    localparam logic [7:0] SEQ_OFS     = 8'd0;
    localparam logic [7:0] PRODUCT_OFS = 8'd30;
    localparam logic [7:0] PRICE_OFS   = 8'd34;
    localparam logic [7:0] SIDE_OFS    = 8'd40;

    typedef struct packed {
        logic [15:0] product;
        logic [31:0] price;
        logic        buy_nsell;
    } order_t;

    localparam int ORDER_W = $bits(order_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        EOP  = 2'd2
    } state_t;

    // Fixed-field packet byte; bytes outside the named fields are zero.
    function automatic logic [7:0] field_byte(input logic [7:0] idx, input logic [31:0] seq,
                                              input order_t ord);
        logic [7:0] b;
        case (idx)
            SEQ_OFS:                b = seq[31:24];
            SEQ_OFS + 8'd1:         b = seq[23:16];
            SEQ_OFS + 8'd2:         b = seq[15:8];
            SEQ_OFS + 8'd3:         b = seq[7:0];
            PRODUCT_OFS:            b = ord.product[15:8];
            PRODUCT_OFS + 8'd1:     b = ord.product[7:0];
            PRICE_OFS:              b = ord.price[31:24];
            PRICE_OFS + 8'd1:       b = ord.price[23:16];
            PRICE_OFS + 8'd2:       b = ord.price[15:8];
            PRICE_OFS + 8'd3:       b = ord.price[7:0];
            SIDE_OFS:               b = {7'b0000000, ord.buy_nsell};
            default:                b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/order_tx_hold.sv
// One-entry order hold register; accepts a new order in the same cycle the held one unloads.
module order_tx_hold
    import order_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               order_valid,
    input  logic [ORDER_W-1:0] order_in,
    input  logic               unload,
    output logic               order_ready,
    output logic               full,
    output logic [ORDER_W-1:0] order_out
);

    logic               full_r;
    logic               alive_r;
    logic [ORDER_W-1:0] data_r;
    logic               accept_s;

    // alive_r keeps ready low until the first edge after reset release
    assign order_ready = alive_r && (!full_r || unload);
    assign accept_s    = order_valid && order_ready;
    assign full        = full_r;
    assign order_out   = data_r;

    // Occupancy and payload of the hold slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_r  <= 1'b0;
            alive_r <= 1'b0;
            data_r  <= '0;
        end else begin
            alive_r <= 1'b1;
            if (accept_s) begin
                full_r <= 1'b1;
                data_r <= order_in;
            end else if (unload) begin
                full_r <= 1'b0;
            end else begin
                full_r <= full_r;
            end
        end
    end

endmodule

// File: rtl/order_tx.sv
// Order packet serializer: turns held orders into PKT_LEN-byte packets with a trailing EOP pulse.
// Define ORDER_TX_CHECKSUM_EN to send the last byte as the XOR of all preceding bytes.
module order_tx
    import order_pkg::*;
#(
    parameter int          PKT_LEN  = 48,
    parameter logic [31:0] SEQ_INIT = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        order_valid,
    output logic        order_ready,
    input  logic [15:0] order_product,
    input  logic [31:0] order_price,
    input  logic        order_buy_nsell,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic [31:0] seq_num
);

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    logic        hold_full_s;
    order_t      hold_order_s;
    logic        unload_s;
    logic        xfer_s;
    logic [7:0]  next_byte_s;

    state_t      state_r;
    logic [31:0] seq_r;
    logic [31:0] pkt_seq_r;
    order_t      pkt_order_r;
    logic [7:0]  ld_idx_r;
    logic        last_r;
    logic [7:0]  tx_data_r;
    logic        tx_valid_r;
    logic        tx_sop_r;
    logic        tx_eop_r;
`ifdef ORDER_TX_CHECKSUM_EN
    logic [7:0]  csum_r;
`endif

    order_tx_hold u_hold (
        .clk         (clk),
        .rst         (rst),
        .order_valid (order_valid),
        .order_in    ({order_product, order_price, order_buy_nsell}),
        .unload      (unload_s),
        .order_ready (order_ready),
        .full        (hold_full_s),
        .order_out   (hold_order_s)
    );

    assign xfer_s   = tx_valid_r && tx_ready;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign tx_sop   = tx_sop_r;
    assign tx_eop   = tx_eop_r;
    assign seq_num  = seq_r;

    // Hold slot drains whenever the serializer is between packets
    always_comb begin
        unload_s = 1'b0;
        if (hold_full_s && (state_r == IDLE || state_r == EOP)) begin
            unload_s = 1'b1;
        end else begin
            unload_s = 1'b0;
        end
    end

    // Byte to present after the current one transfers; the final byte is only loaded on a transfer
    always_comb begin
        next_byte_s = 8'h00;
        if (ld_idx_r == LAST_IDX) begin
`ifdef ORDER_TX_CHECKSUM_EN
            next_byte_s = xor_fold(csum_r, tx_data_r);
`else
            next_byte_s = 8'h00;
`endif
        end else begin
            next_byte_s = field_byte(ld_idx_r, pkt_seq_r, pkt_order_r);
        end
    end

    // Packet FSM and registered stream outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            seq_r       <= SEQ_INIT;
            pkt_seq_r   <= 32'h0000_0000;
            pkt_order_r <= '0;
            ld_idx_r    <= 8'd0;
            last_r      <= 1'b0;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            tx_sop_r    <= 1'b0;
            tx_eop_r    <= 1'b0;
`ifdef ORDER_TX_CHECKSUM_EN
            csum_r      <= 8'h00;
`endif
        end else begin
            case (state_r)
                IDLE, EOP: begin
                    tx_eop_r <= 1'b0;
                    if (unload_s) begin
                        state_r     <= SEND;
                        pkt_seq_r   <= seq_r;
                        pkt_order_r <= hold_order_s;
                        tx_data_r   <= field_byte(SEQ_OFS, seq_r, hold_order_s);
                        tx_valid_r  <= 1'b1;
                        tx_sop_r    <= 1'b1;
                        ld_idx_r    <= 8'd1;
                        last_r      <= 1'b0;
`ifdef ORDER_TX_CHECKSUM_EN
                        csum_r      <= 8'h00;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEND: begin
                    if (xfer_s && last_r) begin
                        state_r    <= EOP;
                        seq_r      <= seq_r + 32'd1;
                        tx_data_r  <= 8'h00;
                        tx_valid_r <= 1'b0;
                        tx_sop_r   <= 1'b0;
                        tx_eop_r   <= 1'b1;
                        ld_idx_r   <= 8'd0;
                        last_r     <= 1'b0;
                    end else if (xfer_s) begin
                        tx_data_r <= next_byte_s;
                        tx_sop_r  <= 1'b0;
                        last_r    <= (ld_idx_r == LAST_IDX);
                        ld_idx_r  <= ld_idx_r + 8'd1;
                    end else begin
                        tx_data_r <= tx_data_r;
                    end
`ifdef ORDER_TX_CHECKSUM_EN
                    if (xfer_s) begin
                        csum_r <= xor_fold(csum_r, tx_data_r);
                    end else begin
                        csum_r <= csum_r;
                    end
`endif
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_order_tx.sv
// Self-checking bench for order_tx: packet-level reference model plus pinned literal expectations.
module tb_order_tx;

    localparam int          PKT_LEN = 48;
    localparam logic [31:0] INIT0   = 32'h0000_0000;
    localparam logic [31:0] INIT1   = 32'hFFFF_FFFF;

    typedef struct {
        logic [15:0] product;
        logic [31:0] price;
        logic        side;
    } ord_s;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        order_valid = 1'b0;
    logic [15:0] order_product = 16'h0000;
    logic [31:0] order_price = 32'h0000_0000;
    logic        order_buy_nsell = 1'b0;
    logic        tx_ready = 1'b1;
    logic        toggle = 1'b0;

    logic        order_ready [2];
    logic [7:0]  tx_data [2];
    logic        tx_valid [2];
    logic        tx_sop [2];
    logic        tx_eop [2];
    logic [31:0] seq_num [2];

    int checks = 0;
    int failures = 0;

    ord_s        orders[$];
    int          gap_q[$];
    int          idx [2];
    int          started [2];
    int          vcyc [2];
    int          done_vcyc [2];
    int          eop_cyc [2];
    bit          first_ready [2];
    bit          in_pkt [2];
    bit          eop_due [2];
    bit          stall [2];
    bit          alive;
    int          cyc;
    logic [7:0]  prev_data [2];
    logic        prev_sop [2];
    logic [31:0] m_seq [2];
    logic [7:0]  exp_b [2][PKT_LEN];
    logic [7:0]  cap [2][PKT_LEN];

    order_tx #(.PKT_LEN(PKT_LEN), .SEQ_INIT(INIT0)) u_dut0 (
        .clk(clk), .rst(rst), .order_valid(order_valid), .order_ready(order_ready[0]),
        .order_product(order_product), .order_price(order_price),
        .order_buy_nsell(order_buy_nsell), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready), .tx_sop(tx_sop[0]), .tx_eop(tx_eop[0]), .seq_num(seq_num[0])
    );

    order_tx #(.PKT_LEN(PKT_LEN), .SEQ_INIT(INIT1)) u_dut1 (
        .clk(clk), .rst(rst), .order_valid(order_valid), .order_ready(order_ready[1]),
        .order_product(order_product), .order_price(order_price),
        .order_buy_nsell(order_buy_nsell), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready), .tx_sop(tx_sop[1]), .tx_eop(tx_eop[1]), .seq_num(seq_num[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected packet straight from the byte layout rules
    task automatic build_pkt(input int d, input ord_s o);
        logic [7:0] x;
        for (int i = 0; i < PKT_LEN; i++) exp_b[d][i] = 8'h00;
        exp_b[d][0]  = m_seq[d][31:24];
        exp_b[d][1]  = m_seq[d][23:16];
        exp_b[d][2]  = m_seq[d][15:8];
        exp_b[d][3]  = m_seq[d][7:0];
        exp_b[d][30] = o.product[15:8];
        exp_b[d][31] = o.product[7:0];
        exp_b[d][34] = o.price[31:24];
        exp_b[d][35] = o.price[23:16];
        exp_b[d][36] = o.price[15:8];
        exp_b[d][37] = o.price[7:0];
        exp_b[d][40] = {7'b0000000, o.side};
        x = 8'h00;
        for (int i = 0; i < PKT_LEN - 1; i++) x = x ^ exp_b[d][i];
`ifdef ORDER_TX_CHECKSUM_EN
        exp_b[d][PKT_LEN-1] = x;
`else
        exp_b[d][PKT_LEN-1] = 8'h00;
`endif
    endtask

    task automatic mon(input int d, input logic rdy, input logic v, input logic sop,
                       input logic eop, input logic [7:0] data, input logic [31:0] sq);
        if (eop_due[d]) begin
            chk("eop_pulse", {v, eop}, 2'b01);
            eop_due[d] = 1'b0;
            m_seq[d] = m_seq[d] + 32'd1;
            eop_cyc[d] = cyc;
        end else begin
            chk("eop_idle", eop, 1'b0);
        end
        chk("seq_num", sq, m_seq[d]);
        if (stall[d]) chk("stall_hold", {v, sop, data}, {1'b1, prev_sop[d], prev_data[d]});
        if (in_pkt[d] && !v) chk("no_bubble", v, 1'b1);
        if (alive && !rdy) chk("ready_only_when_held", (orders.size() > started[d]), 1'b1);
        if (v) begin
            if (!in_pkt[d]) begin
                if (started[d] < orders.size()) begin
                    build_pkt(d, orders[started[d]]);
                    started[d]++;
                    in_pkt[d] = 1'b1;
                    idx[d] = 0;
                    vcyc[d] = 0;
                    first_ready[d] = tx_ready;
                    if (d == 0) gap_q.push_back(cyc - eop_cyc[d]);
                end else begin
                    chk("unexpected_packet", v, 1'b0);
                end
            end
            if (in_pkt[d]) begin
                vcyc[d]++;
                chk("tx_data", data, exp_b[d][idx[d]]);
                chk("tx_sop", sop, (idx[d] == 0));
                if (tx_ready) begin
                    cap[d][idx[d]] = data;
                    idx[d]++;
                    if (idx[d] == PKT_LEN) begin
                        in_pkt[d] = 1'b0;
                        eop_due[d] = 1'b1;
                        done_vcyc[d] = vcyc[d];
                    end
                end
            end
        end
        stall[d] = v && !tx_ready;
        prev_data[d] = data;
        prev_sop[d] = sop;
    endtask

    // Compare process: model reset while rst is low, otherwise check both instances every cycle
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                in_pkt[d] = 1'b0; eop_due[d] = 1'b0; stall[d] = 1'b0; idx[d] = 0;
                started[d] = orders.size();
                m_seq[d] = (d == 0) ? INIT0 : INIT1;
            end
            alive = 1'b0;
        end else begin
            cyc++;
            mon(0, order_ready[0], tx_valid[0], tx_sop[0], tx_eop[0], tx_data[0], seq_num[0]);
            mon(1, order_ready[1], tx_valid[1], tx_sop[1], tx_eop[1], tx_data[1], seq_num[1]);
            alive = 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle) tx_ready = ~tx_ready;
            else tx_ready = 1'b1;
        end
    end

    task automatic send_order(input logic [15:0] p, input logic [31:0] pr, input logic s,
                              input bit keep);
        bit ok;
        ok = 1'b0;
        order_valid = 1'b1;
        order_product = p;
        order_price = pr;
        order_buy_nsell = s;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (order_ready[0]) begin
                orders.push_back('{p, pr, s});
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 1'b0, 1'b1);
        if (!keep) order_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            done = (started[0] == orders.size()) && (started[1] == orders.size()) &&
                   !in_pkt[0] && !in_pkt[1] && !eop_due[0] && !eop_due[1];
        end
        if (!done) chk("packet_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] x;
        bit hit;
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", tx_valid[0], 1'b0);
        chk("rst_ready", order_ready[0], 1'b0);
        chk("rst_seq1", seq_num[1], INIT1);
        rst = 1'b1;
        chk("ready_before_edge", order_ready[0], 1'b0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", order_ready[0], 1'b1);

        // Single order, tx_ready high
        send_order(16'd4321, 32'd800, 1'b1, 1'b0);
        wait_done();
        chk("t1_b30", cap[0][30], 8'h10);
        chk("t1_b31", cap[0][31], 8'hE1);
        chk("t1_price", {cap[0][34], cap[0][35], cap[0][36], cap[0][37]}, 32'h0000_0320);
        chk("t1_b40", cap[0][40], 8'h01);
        chk("t1_seq_after", seq_num[0], 32'd1);
        chk("t1_wrap_bytes", {cap[1][0], cap[1][1], cap[1][2], cap[1][3]}, 32'hFFFF_FFFF);
        chk("t1_wrap_seq", seq_num[1], 32'h0000_0000);

        // tx_ready toggling every cycle
        toggle = 1'b1;
        send_order(16'h1234, 32'hDEAD_BEEF, 1'b0, 1'b0);
        wait_done();
        toggle = 1'b0;
        chk("t2_data_cycles", done_vcyc[0], first_ready[0] ? 32'd95 : 32'd96);
        chk("t2_seq_byte3", cap[0][3], 8'h01);
        chk("t2_wrap_bytes", {cap[1][0], cap[1][1], cap[1][2], cap[1][3]}, 32'h0000_0000);

        // Three back-to-back orders
        gap_q.delete();
        send_order(16'd0, 32'd10, 1'b1, 1'b1);
        send_order(16'd11, 32'd20, 1'b0, 1'b1);
        send_order(16'd29, 32'd30, 1'b1, 1'b0);
        wait_done();
        chk("t3_pkts", gap_q.size(), 32'd3);
        if (gap_q.size() == 3) begin
            chk("t3_gap1", gap_q[1], 32'd1);
            chk("t3_gap2", gap_q[2], 32'd1);
        end
        chk("t3_b31", cap[0][31], 8'd29);
        chk("t3_seq", seq_num[0], 32'd5);

        // Reset at byte 20
        send_order(16'd7, 32'd77, 1'b1, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            hit = in_pkt[0] && (idx[0] == 20);
        end
        if (!hit) chk("byte20_timeout", 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out", {tx_valid[0], tx_sop[0], tx_eop[0], tx_data[0]}, 11'h000);
        chk("mid_rst_ready", order_ready[0], 1'b0);
        chk("mid_rst_seq0", seq_num[0], INIT0);
        chk("mid_rst_seq1", seq_num[1], INIT1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Post-reset order, also the checksum case
        send_order(16'd100, 32'd98765432, 1'b0, 1'b0);
        wait_done();
        chk("t5_seq0", {cap[0][0], cap[0][1], cap[0][2], cap[0][3]}, 32'h0000_0000);
        chk("t5_seq1", {cap[1][0], cap[1][1], cap[1][2], cap[1][3]}, 32'hFFFF_FFFF);
        chk("t5_b31", cap[0][31], 8'h64);
        chk("t5_price", {cap[0][34], cap[0][35], cap[0][36], cap[0][37]}, 32'h05E3_0A78);
        chk("t5_b40", cap[0][40], 8'h00);
        x = 8'h00;
        for (int i = 0; i < PKT_LEN - 1; i++) x = x ^ cap[0][i];
`ifdef ORDER_TX_CHECKSUM_EN
        chk("t5_csum", cap[0][PKT_LEN-1], x);
`else
        chk("t5_last_zero", cap[0][PKT_LEN-1], 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
